// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// fpu_pkg : FP32 field widths and rounding-mode encodings shared by the FPU
//           datapaths (fadd, fmul, itof).
// Revision: 1.0
// ============================================================================
package fpu_pkg;

  localparam int EW   = 8;
  localparam int MW   = 23;
  localparam int BIAS = 127;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RTZ = 2'b01,
    RM_RDN = 2'b10,
    RM_RUP = 2'b11
  } rm_t;

  typedef struct packed {
    logic          s;
    logic [EW-1:0] e;
    logic [MW-1:0] m;
  } fp32_t;

endpackage
`default_nettype wire

// File: rtl/itof_lzc.sv
`default_nettype none
// ============================================================================
// itof_lzc : combinational leading-zero counter, balanced tree form.
//            Returns W for an all-zero input.
// Revision: 1.0
// ============================================================================
module itof_lzc #(
  parameter int W = 32
) (
  input  logic [W-1:0]       x,
  output logic [$clog2(W):0] lz
);

  localparam int L = $clog2(W);
  localparam int P = 1 << L;

  // Level l holds P>>l nodes of l+1 bits each, packed back to back.
  function automatic int lvl_off(input int l);
    int o;
    o = 0;
    for (int j = 0; j < l; j++) o += (P >> j) * (j + 1);
    return o;
  endfunction

  localparam int TOT  = lvl_off(L + 1);
  localparam int ROOT = lvl_off(L);

  logic [P-1:0]   w_pad;
  logic [TOT-1:0] w_tree;

  // Ones below the operand keep the count capped at W for a zero input.
  if (P > W) begin : g_pad
    assign w_pad = {x, {(P-W){1'b1}}};
  end else begin : g_nopad
    assign w_pad = x;
  end

  for (genvar l = 0; l <= L; l++) begin : g_lvl
    localparam int N   = P >> l;
    localparam int OFF = lvl_off(l);
    for (genvar i = 0; i < N; i++) begin : g_node
      if (l == 0) begin : g_leaf
        assign w_tree[OFF + i] = ~w_pad[i];
      end else begin : g_join
        localparam int COFF = lvl_off(l - 1);
        logic [l-1:0] w_hi;
        logic [l-1:0] w_lo;
        assign w_hi = w_tree[COFF + (2*i+1)*l +: l];
        assign w_lo = w_tree[COFF + (2*i)*l +: l];
        assign w_tree[OFF + i*(l+1) +: l+1] =
          w_hi[l-1] ? ({1'b0, w_hi} + {1'b0, w_lo}) : {1'b0, w_hi};
      end
    end
  end

  assign lz = w_tree[ROOT +: L+1];

endmodule
`default_nettype wire

// File: rtl/itof_pipe.sv
`default_nettype none
// ============================================================================
// itof_pipe : 3-stage integer-to-FP32 converter, valid/ready handshake,
//             signed/unsigned operands, four IEEE rounding modes.
// Revision: 1.0
// ============================================================================
module itof_pipe
  import fpu_pkg::*;
#(
  parameter int IW     = 32,
  parameter int STAGES = 3
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_x,
  input  logic          in_signed,
  input  logic [1:0]    in_rm,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_y,
  output logic          out_nx
);

  localparam int LZW = $clog2(IW) + 1;
  localparam int XW  = IW + MW + 1;

  if (STAGES != 3) begin : g_bad_stages
    $error("itof_pipe: STAGES must be 3");
  end
  if (IW < 8 || IW > 64) begin : g_bad_iw
    $error("itof_pipe: IW must be within 8..64");
  end

  logic w_en;
  assign w_en     = ~out_valid | out_ready;
  assign in_ready = w_en;

  // ---------------- S1: sign, magnitude, leading-zero count ----------------
  logic           w_neg;
  logic [IW-1:0]  w_mag;
  logic [LZW-1:0] w_lz;

  assign w_neg = in_signed & in_x[IW-1];
  assign w_mag = w_neg ? -in_x : in_x;

  itof_lzc #(.W(IW)) u_lzc (
    .x  (w_mag),
    .lz (w_lz)
  );

  logic           r1_v;
  logic           r1_s;
  logic [IW-1:0]  r1_mag;
  logic [LZW-1:0] r1_lz;
  logic           r1_zero;
  rm_t            r1_rm;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r1_v    <= 1'b0;
      r1_s    <= 1'b0;
      r1_mag  <= '0;
      r1_lz   <= '0;
      r1_zero <= 1'b0;
      r1_rm   <= RM_RNE;
    end else if (w_en) begin
      r1_v    <= in_valid;
      r1_s    <= w_neg;
      r1_mag  <= w_mag;
      r1_lz   <= w_lz;
      r1_zero <= (w_mag == '0);
      r1_rm   <= rm_t'(in_rm);
    end
  end

  // ---------------- S2: normalise, exponent, rounding decision -------------
  logic [IW-1:0] w_norm;
  logic [XW-1:0] w_ext;
  logic [MW-1:0] w_frac;
  logic          w_g;
  logic          w_st;
  logic [EW-1:0] w_e;
  logic          w_inc;

  assign w_norm = r1_mag << r1_lz;
  // Zero fill below the operand covers narrow inputs that need no rounding.
  assign w_ext  = {w_norm, {(MW+1){1'b0}}};
  assign w_frac = w_ext[XW-2 -: MW];
  assign w_g    = w_ext[IW-1];
  assign w_st   = |w_ext[IW-2:0];
  assign w_e    = EW'(BIAS + IW - 1) - EW'(r1_lz);

  always_comb begin
    w_inc = 1'b0;
    case (r1_rm)
      RM_RNE:  w_inc = w_g & (w_st | w_frac[0]);
      RM_RTZ:  w_inc = 1'b0;
      RM_RDN:  w_inc = r1_s & (w_g | w_st);
      RM_RUP:  w_inc = ~r1_s & (w_g | w_st);
      default: w_inc = 1'b0;
    endcase
  end

  logic          r2_v;
  logic          r2_s;
  logic [MW-1:0] r2_m;
  logic [EW-1:0] r2_e;
  logic          r2_inc;
  logic          r2_nx;
  logic          r2_zero;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r2_v    <= 1'b0;
      r2_s    <= 1'b0;
      r2_m    <= '0;
      r2_e    <= '0;
      r2_inc  <= 1'b0;
      r2_nx   <= 1'b0;
      r2_zero <= 1'b0;
    end else if (w_en) begin
      r2_v    <= r1_v;
      r2_s    <= r1_s;
      r2_m    <= w_frac;
      r2_e    <= w_e;
      r2_inc  <= w_inc;
      r2_nx   <= w_g | w_st;
      // A missing leading one after normalisation only happens for zero.
      r2_zero <= r1_zero | ~w_ext[XW-1];
    end
  end

  // ---------------- S3: mantissa increment and result assembly -------------
  logic [MW:0]   w_sum;
  logic [EW-1:0] w_e3;

  // A carry out leaves the mantissa at zero and bumps the exponent.
  assign w_sum = {1'b0, r2_m} + {{MW{1'b0}}, r2_inc};
  assign w_e3  = r2_e + {{(EW-1){1'b0}}, w_sum[MW]};

  logic  r3_v;
  fp32_t r3_y;
  logic  r3_nx;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r3_v  <= 1'b0;
      r3_y  <= '0;
      r3_nx <= 1'b0;
    end else if (w_en) begin
      r3_v  <= r2_v;
      r3_y  <= r2_zero ? fp32_t'('0) : fp32_t'({r2_s, w_e3, w_sum[MW-1:0]});
      r3_nx <= r2_nx & ~r2_zero;
    end
  end

  assign out_valid = r3_v;
  assign out_y     = r3_y;
  assign out_nx    = r3_nx;

endmodule
`default_nettype wire

// File: tb/tb_itof_pipe.sv
`default_nettype none
// tb_itof_pipe : directed and randomized checks of itof_pipe at IW = 8, 32, 64
//                against an arithmetic rounding model.
module tb_itof_pipe;

  localparam int ND = 3;

  typedef struct {
    logic [63:0] x;
    bit          sg;
    logic [1:0]  rm;
    int          cyc;
  } op_t;

  typedef struct {
    logic [31:0] y;
    logic        nx;
    int          cyc;
  } res_t;

  typedef struct {
    string       nm;
    int          d;
    logic [63:0] x;
    bit          sg;
    logic [1:0]  rm;
    logic [31:0] y;
    bit          nx;
  } vec_t;

  logic        clk;
  logic        rstn;
  logic        in_valid_a  [ND];
  logic        in_ready_a  [ND];
  logic [63:0] in_x_a      [ND];
  logic        in_signed_a [ND];
  logic [1:0]  in_rm_a     [ND];
  logic        out_valid_a [ND];
  logic        out_ready_a [ND];
  logic [31:0] out_y_a     [ND];
  logic        out_nx_a    [ND];

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  op_t  pend_q[$];
  op_t  acc_q[$];
  res_t res_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  itof_pipe #(.IW(8), .STAGES(3)) u_d8 (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]), .in_x(in_x_a[0][7:0]),
    .in_signed(in_signed_a[0]), .in_rm(in_rm_a[0]),
    .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]),
    .out_y(out_y_a[0]), .out_nx(out_nx_a[0]));

  itof_pipe #(.IW(32), .STAGES(3)) u_d32 (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]), .in_x(in_x_a[1][31:0]),
    .in_signed(in_signed_a[1]), .in_rm(in_rm_a[1]),
    .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]),
    .out_y(out_y_a[1]), .out_nx(out_nx_a[1]));

  itof_pipe #(.IW(64), .STAGES(3)) u_d64 (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]), .in_x(in_x_a[2]),
    .in_signed(in_signed_a[2]), .in_rm(in_rm_a[2]),
    .out_valid(out_valid_a[2]), .out_ready(out_ready_a[2]),
    .out_y(out_y_a[2]), .out_nx(out_nx_a[2]));

  function automatic int iw_of(input int d);
    return (d == 0) ? 8 : ((d == 1) ? 32 : 64);
  endfunction

  function automatic logic [63:0] msk(input int iw);
    return (iw == 64) ? {64{1'b1}} : ((64'd1 << iw) - 64'd1);
  endfunction

  // Exact integer value rounded to a 24-bit significand; returns {nx, fp32}.
  function automatic logic [32:0] ref_conv(input logic [63:0] x, input int iw,
                                           input bit sg, input logic [1:0] rm);
    logic [64:0] mag, q, rem, half;
    bit s, up, nx;
    int k, sh;
    s = sg && x[iw-1];
    mag = s ? ((65'd1 << iw) - {1'b0, x}) : {1'b0, x};
    if (mag == 65'd0) return 33'd0;
    k = 0;
    while ((mag >> (k + 1)) != 65'd0) k++;
    up = 0;
    nx = 0;
    if (k <= 23) begin
      q = mag << (23 - k);
    end else begin
      sh   = k - 23;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = 65'd1 << (sh - 1);
      nx   = (rem != 65'd0);
      case (rm)
        2'd0:    up = (rem > half) || ((rem == half) && q[0]);
        2'd1:    up = 0;
        2'd2:    up = s && nx;
        default: up = !s && nx;
      endcase
      q = q + 65'(up);
      if (q == (65'd1 << 24)) begin
        q = q >> 1;
        k++;
      end
    end
    return {nx, s, 8'(127 + k), q[22:0]};
  endfunction

  function automatic op_t rand_op(input int d);
    op_t o;
    logic [63:0] r;
    int iw;
    iw = iw_of(d);
    r  = {$urandom, $urandom} >> $urandom_range(63, 0);
    case ($urandom_range(15, 0))
      0:       r = 64'd0;
      1:       r = {64{1'b1}};
      2:       r = 64'd1 << (iw - 1);
      default: ;
    endcase
    o.x   = r & msk(iw);
    o.sg  = 1'($urandom_range(1, 0));
    o.rm  = 2'($urandom_range(3, 0));
    o.cyc = 0;
    return o;
  endfunction

  task automatic clear_q();
    pend_q.delete();
    acc_q.delete();
    res_q.delete();
  endtask

  task automatic drive(input int d, input bit v, input bit rdy);
    in_valid_a[d]  = v && (pend_q.size() > 0);
    out_ready_a[d] = rdy;
    if (pend_q.size() > 0) begin
      in_x_a[d]      = pend_q[0].x;
      in_signed_a[d] = pend_q[0].sg;
      in_rm_a[d]     = pend_q[0].rm;
    end
  endtask

  // Records the handshakes that happen on the coming edge, then advances.
  task automatic cycle(input int d);
    op_t  o;
    res_t r;
    #1;
    if (in_valid_a[d] && in_ready_a[d]) begin
      o     = pend_q[0];
      o.cyc = cyc + 1;
      acc_q.push_back(o);
      pend_q.delete(0);
    end
    if (out_valid_a[d] && out_ready_a[d]) begin
      r.y   = out_y_a[d];
      r.nx  = out_nx_a[d];
      r.cyc = cyc + 1;
      res_q.push_back(r);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input int d, input int rdy_pct, input int gap_pct, input int budget);
    int target, n;
    target = acc_q.size() + pend_q.size();
    n = 0;
    while (res_q.size() < target && n < budget) begin
      drive(d, $urandom_range(99, 0) >= gap_pct, $urandom_range(99, 0) < rdy_pct);
      cycle(d);
      n++;
    end
    in_valid_a[d]  = 1'b0;
    out_ready_a[d] = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    #1 rstn = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (out_valid_a[d] !== 1'b0 || out_y_a[d] !== 32'h0 || out_nx_a[d] !== 1'b0 ||
          in_ready_a[d] !== 1'b1) begin
        errors++;
        $display("FAIL reset[iw=%0d] valid/y/nx/ready got %b/%h/%b/%b want 0/00000000/0/1",
                 iw_of(d), out_valid_a[d], out_y_a[d], out_nx_a[d], in_ready_a[d]);
      end
    end
    @(posedge clk);
    @(posedge clk);
    #3 rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    vec_t tbl[$];
    vec_t t;
    tbl.push_back('{"one",         1, 64'h00000001, 1'b0, 2'd0, 32'h3F800000, 1'b0});
    tbl.push_back('{"minus_one",   1, 64'hFFFFFFFF, 1'b1, 2'd0, 32'hBF800000, 1'b0});
    tbl.push_back('{"zero_rne",    1, 64'h00000000, 1'b0, 2'd0, 32'h00000000, 1'b0});
    tbl.push_back('{"zero_rdn_s",  1, 64'h00000000, 1'b1, 2'd2, 32'h00000000, 1'b0});
    tbl.push_back('{"int_min",     1, 64'h80000000, 1'b1, 2'd0, 32'hCF000000, 1'b0});
    tbl.push_back('{"tie_rne",     1, 64'h01000001, 1'b0, 2'd0, 32'h4B800000, 1'b1});
    tbl.push_back('{"tie_rup",     1, 64'h01000001, 1'b0, 2'd3, 32'h4B800001, 1'b1});
    tbl.push_back('{"tie_rtz",     1, 64'h01000001, 1'b0, 2'd1, 32'h4B800000, 1'b1});
    tbl.push_back('{"tie_odd_rne", 1, 64'h01000003, 1'b0, 2'd0, 32'h4B800002, 1'b1});
    tbl.push_back('{"neg_rdn",     1, 64'hFEFFFFFF, 1'b1, 2'd2, 32'hCB800001, 1'b1});
    tbl.push_back('{"neg_rup",     1, 64'hFEFFFFFF, 1'b1, 2'd3, 32'hCB800000, 1'b1});
    tbl.push_back('{"carry_rne",   1, 64'hFFFFFFFF, 1'b0, 2'd0, 32'h4F800000, 1'b1});
    tbl.push_back('{"carry_rtz",   1, 64'hFFFFFFFF, 1'b0, 2'd1, 32'h4F7FFFFF, 1'b1});
    tbl.push_back('{"smax_rne",    1, 64'h7FFFFFFF, 1'b1, 2'd0, 32'h4F000000, 1'b1});
    tbl.push_back('{"w8_min",      0, 64'h00000080, 1'b1, 2'd0, 32'hC3000000, 1'b0});
    tbl.push_back('{"w8_max",      0, 64'h000000FF, 1'b0, 2'd1, 32'h437F0000, 1'b0});
    tbl.push_back('{"w64_ones",    2, {64{1'b1}},   1'b0, 2'd0, 32'h5F800000, 1'b1});
    foreach (tbl[i]) begin
      t = tbl[i];
      clear_q();
      pend_q.push_back('{t.x, t.sg, t.rm, 0});
      stream(t.d, 100, 0, 30);
      checks++;
      if (res_q.size() != 1) begin
        errors++;
        $display("FAIL %s count got %0d want 1", t.nm, res_q.size());
      end else begin
        checks++;
        if (res_q[0].y !== t.y || res_q[0].nx !== t.nx) begin
          errors++;
          $display("FAIL %s y/nx got %h/%b want %h/%b", t.nm, res_q[0].y, res_q[0].nx, t.y, t.nx);
        end
        checks++;
        if (res_q[0].cyc - acc_q[0].cyc != 3) begin
          errors++;
          $display("FAIL %s latency got %0d want 3", t.nm, res_q[0].cyc - acc_q[0].cyc);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [32:0] e;
    clear_q();
    for (int i = 0; i < 8; i++) pend_q.push_back(rand_op(1));
    stream(1, 100, 0, 50);
    checks++;
    if (res_q.size() != 8 || acc_q.size() != 8) begin
      errors++;
      $display("FAIL b2b count got %0d/%0d want 8/8", acc_q.size(), res_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        e = ref_conv(acc_q[i].x, 32, acc_q[i].sg, acc_q[i].rm);
        checks++;
        if (res_q[i].y !== e[31:0] || res_q[i].nx !== e[32]) begin
          errors++;
          $display("FAIL b2b[%0d] y/nx got %h/%b want %h/%b", i, res_q[i].y, res_q[i].nx, e[31:0], e[32]);
        end
        checks++;
        if (res_q[i].cyc - acc_q[i].cyc != 3) begin
          errors++;
          $display("FAIL b2b_lat[%0d] got %0d want 3", i, res_q[i].cyc - acc_q[i].cyc);
        end
        if (i > 0) begin
          checks++;
          if (res_q[i].cyc != res_q[i-1].cyc + 1 || acc_q[i].cyc != acc_q[i-1].cyc + 1) begin
            errors++;
            $display("FAIL b2b_gap[%0d] acc/res step got %0d/%0d want 1/1", i,
                     acc_q[i].cyc - acc_q[i-1].cyc, res_q[i].cyc - res_q[i-1].cyc);
          end
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] held_y;
    logic        held_nx;
    logic [32:0] e;
    clear_q();
    for (int i = 0; i < 12; i++) pend_q.push_back(rand_op(1));
    for (int i = 0; i < 4; i++) begin
      drive(1, 1'b1, 1'b1);
      cycle(1);
    end
    held_y  = out_y_a[1];
    held_nx = out_nx_a[1];
    checks++;
    if (out_valid_a[1] !== 1'b1) begin
      errors++;
      $display("FAIL stall_pre out_valid got %b want 1", out_valid_a[1]);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1, 1'b1, 1'b0);
      cycle(1);
      checks++;
      if (in_ready_a[1] !== 1'b0 || out_valid_a[1] !== 1'b1 ||
          out_y_a[1] !== held_y || out_nx_a[1] !== held_nx) begin
        errors++;
        $display("FAIL stall[%0d] ready/valid/y/nx got %b/%b/%h/%b want 0/1/%h/%b", i,
                 in_ready_a[1], out_valid_a[1], out_y_a[1], out_nx_a[1], held_y, held_nx);
      end
    end
    stream(1, 100, 0, 100);
    checks++;
    if (res_q.size() != 12 || acc_q.size() != 12) begin
      errors++;
      $display("FAIL stall_count acc/res got %0d/%0d want 12/12", acc_q.size(), res_q.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        e = ref_conv(acc_q[i].x, 32, acc_q[i].sg, acc_q[i].rm);
        checks++;
        if (res_q[i].y !== e[31:0] || res_q[i].nx !== e[32]) begin
          errors++;
          $display("FAIL stall_res[%0d] y/nx got %h/%b want %h/%b", i, res_q[i].y, res_q[i].nx, e[31:0], e[32]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    op_t o;
    logic [32:0] e;
    clear_q();
    for (int i = 0; i < 3; i++) begin
      o = rand_op(1);
      o.x = o.x | 64'h1;
      pend_q.push_back(o);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 1'b1, 1'b0);
      cycle(1);
    end
    in_valid_a[1] = 1'b0;
    checks++;
    if (out_valid_a[1] !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre out_valid got %b want 1", out_valid_a[1]);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (out_valid_a[1] !== 1'b0 || out_y_a[1] !== 32'h0 || out_nx_a[1] !== 1'b0 ||
        in_ready_a[1] !== 1'b1) begin
      errors++;
      $display("FAIL arst valid/y/nx/ready got %b/%h/%b/%b want 0/00000000/0/1",
               out_valid_a[1], out_y_a[1], out_nx_a[1], in_ready_a[1]);
    end
    @(posedge clk);
    #3 rstn = 1'b1;
    @(posedge clk);
    #1;
    out_ready_a[1] = 1'b1;
    clear_q();
    pend_q.push_back(rand_op(1));
    stream(1, 100, 0, 30);
    checks++;
    if (res_q.size() != 1) begin
      errors++;
      $display("FAIL arst_post count got %0d want 1", res_q.size());
    end else begin
      e = ref_conv(acc_q[0].x, 32, acc_q[0].sg, acc_q[0].rm);
      checks++;
      if (res_q[0].y !== e[31:0] || res_q[0].nx !== e[32]) begin
        errors++;
        $display("FAIL arst_post y/nx got %h/%b want %h/%b", res_q[0].y, res_q[0].nx, e[31:0], e[32]);
      end
    end
  endtask

  task automatic test_sweep(input int d, input int n);
    logic [32:0] e;
    int iw;
    iw = iw_of(d);
    clear_q();
    for (int i = 0; i < n; i++) pend_q.push_back(rand_op(d));
    stream(d, 70, 25, 20 * n);
    checks++;
    if (res_q.size() != n || acc_q.size() != n) begin
      errors++;
      $display("FAIL sweep%0d count acc/res got %0d/%0d want %0d", iw, acc_q.size(), res_q.size(), n);
    end
    for (int i = 0; i < res_q.size() && i < acc_q.size(); i++) begin
      e = ref_conv(acc_q[i].x, iw, acc_q[i].sg, acc_q[i].rm);
      checks++;
      if (res_q[i].y !== e[31:0] || res_q[i].nx !== e[32]) begin
        errors++;
        $display("FAIL sweep%0d[%0d] x=%h s=%b rm=%0d y/nx got %h/%b want %h/%b", iw, i,
                 acc_q[i].x, acc_q[i].sg, acc_q[i].rm, res_q[i].y, res_q[i].nx, e[31:0], e[32]);
      end
    end
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin
      in_valid_a[d]  = 1'b0;
      in_x_a[d]      = 64'd0;
      in_signed_a[d] = 1'b0;
      in_rm_a[d]     = 2'd0;
      out_ready_a[d] = 1'b1;
    end
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_async_reset();
    test_sweep(0, 150);
    test_sweep(2, 150);
    test_sweep(1, 100);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
